// File: rtl/spad_pkg.sv
// ============================================================================
// Module : spad_pkg
// Brief  : Shared scratchpad defaults and the circular-pointer wrap helper.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package spad_pkg;

    localparam int ACT_WIDTH   = 16;
    localparam int IFMAP_DEPTH = 12;

    // Single conditional subtract; valid while ptr < depth and n <= depth.
    function automatic int unsigned ptr_wrap_add(
        input int unsigned ptr,
        input int unsigned n,
        input int unsigned depth
    );
        int unsigned w_sum;
        w_sum = ptr + n;
        return (w_sum >= depth) ? (w_sum - depth) : w_sum;
    endfunction

endpackage

`default_nettype wire

// File: rtl/spad_ring_ptr.sv
// ============================================================================
// Module : spad_ring_ptr
// Brief  : Circular pointer register, advance by 0..DEPTH per cycle.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module spad_ring_ptr #(
    parameter int DEPTH = 12,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clear,
    input  logic [PTR_W:0]   i_adv,
    output logic [PTR_W-1:0] o_ptr
);

    localparam logic [PTR_W:0] c_DEPTH = (PTR_W + 1)'(DEPTH);

    logic [PTR_W-1:0] r_ptr;
    logic [PTR_W:0]   w_sum;
    logic [PTR_W:0]   w_wrapped;

    // One extra bit holds ptr + n up to 2*DEPTH-1 before the wrap subtract.
    always_comb begin
        w_sum     = {1'b0, r_ptr} + i_adv;
        w_wrapped = (w_sum >= c_DEPTH) ? (w_sum - c_DEPTH) : w_sum;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr <= '0;
        end else if (i_clear) begin
            r_ptr <= '0;
        end else begin
            r_ptr <= PTR_W'(w_wrapped);
        end
    end

    assign o_ptr = r_ptr;

endmodule

`default_nettype wire

// File: rtl/ifmap_window_spad.sv
// ============================================================================
// Module : ifmap_window_spad
// Brief  : Circular sliding-window ifmap scratchpad: push at tail, read by
//          offset from head, retire oldest entries by a programmable stride.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module ifmap_window_spad
    import spad_pkg::*;
#(
    parameter int DATA_WIDTH = ACT_WIDTH,
    parameter int DEPTH      = IFMAP_DEPTH,
    parameter int PTR_W      = $clog2(DEPTH),
    parameter int CNT_W      = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [PTR_W-1:0]      rd_offset,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic                  rd_err,
    input  logic                  slide_en,
    input  logic [PTR_W:0]        slide_amt,
    output logic [CNT_W-1:0]      count,
    output logic                  full,
    output logic                  empty
);

    localparam logic [CNT_W-1:0] c_DEPTH_CNT = CNT_W'(DEPTH);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [CNT_W-1:0]      r_count;
    logic [DATA_WIDTH-1:0] r_rd_data;
    logic                  r_rd_valid;
    logic                  r_rd_err;

    logic [PTR_W-1:0]      w_head;
    logic [PTR_W-1:0]      w_tail;
    logic [PTR_W-1:0]      w_rd_addr;
    logic [PTR_W:0]        w_count_ext;
    logic [PTR_W:0]        w_push_n;
    logic [PTR_W:0]        w_eff;
    logic [PTR_W:0]        w_count_sum;
    logic                  w_push;
    logic                  w_rd_hit;

    // Acceptance looks only at the registered count, so a same-cycle slide
    // never opens a slot in a full buffer.
    assign wr_ready = (r_count < c_DEPTH_CNT);
    assign full     = (r_count == c_DEPTH_CNT);
    assign empty    = (r_count == '0);
    assign count    = r_count;
    assign rd_data  = r_rd_data;
    assign rd_valid = r_rd_valid;
    assign rd_err   = r_rd_err;

    always_comb begin
        w_push      = wr_valid && wr_ready && !clear;
        w_push_n    = (PTR_W + 1)'(w_push);
        w_count_ext = (PTR_W + 1)'(r_count);
        if (!slide_en) begin
            w_eff = '0;
        end else if (slide_amt > w_count_ext) begin
            w_eff = w_count_ext;
        end else begin
            w_eff = slide_amt;
        end
        w_count_sum = w_count_ext + w_push_n - w_eff;
        w_rd_hit    = ({1'b0, rd_offset} < w_count_ext);
        w_rd_addr   = PTR_W'(ptr_wrap_add(32'(w_head), 32'(rd_offset), 32'(DEPTH)));
    end

    spad_ring_ptr #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_head (
        .clk     (clk),
        .rst     (rst),
        .i_clear (clear),
        .i_adv   (w_eff),
        .o_ptr   (w_head)
    );

    spad_ring_ptr #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_tail (
        .clk     (clk),
        .rst     (rst),
        .i_clear (clear),
        .i_adv   (w_push_n),
        .o_ptr   (w_tail)
    );

    // Storage is deliberately not reset; count gating hides stale entries.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[w_tail] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (clear) begin
            r_count <= '0;
        end else begin
            r_count <= CNT_W'(w_count_sum);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
            r_rd_err   <= 1'b0;
        end else if (clear) begin
            r_rd_valid <= 1'b0;
            r_rd_err   <= 1'b0;
        end else if (rd_en) begin
            r_rd_valid <= 1'b1;
            if (w_rd_hit) begin
                r_rd_data <= r_mem[w_rd_addr];
                r_rd_err  <= 1'b0;
            end else begin
                r_rd_data <= '0;
                r_rd_err  <= 1'b1;
            end
        end else begin
            r_rd_valid <= 1'b0;
            r_rd_err   <= 1'b0;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_ifmap_window_spad.sv
// ============================================================================
// Module : tb_ifmap_window_spad
// Brief  : Self-checking bench for ifmap_window_spad with a read scoreboard.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_ifmap_window_spad;

    localparam int DW    = 16;
    localparam int DEPTH = 12;
    localparam int PTR_W = 4;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             clear;
    logic             wr_valid;
    logic             wr_ready;
    logic [DW-1:0]    wr_data;
    logic             rd_en;
    logic [PTR_W-1:0] rd_offset;
    logic [DW-1:0]    rd_data;
    logic             rd_valid;
    logic             rd_err;
    logic             slide_en;
    logic [PTR_W:0]   slide_amt;
    logic [CNT_W-1:0] count;
    logic             full;
    logic             empty;

    typedef struct {
        logic [DW-1:0] data;
        logic          err;
    } exp_t;

    exp_t          sb[$];
    logic [DW-1:0] model[$];
    int            checks = 0;
    int            errors = 0;

    always #5 clk = ~clk;

    ifmap_window_spad #(
        .DATA_WIDTH (DW),
        .DEPTH      (DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .clear     (clear),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .wr_data   (wr_data),
        .rd_en     (rd_en),
        .rd_offset (rd_offset),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid),
        .rd_err    (rd_err),
        .slide_en  (slide_en),
        .slide_amt (slide_amt),
        .count     (count),
        .full      (full),
        .empty     (empty)
    );

    // Read scoreboard: every pending expectation must appear as an rd_valid pulse.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && (rd_valid || sb.size() != 0)) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL rd_unexpected: rd_valid=%b data=%0d err=%b, expected no read result",
                         rd_valid, rd_data, rd_err);
            end else begin
                e = sb.pop_front();
                if (rd_valid !== 1'b1 || rd_data !== e.data || rd_err !== e.err) begin
                    errors++;
                    $display("FAIL rd_result: got valid=%b data=%0d err=%b, expected valid=1 data=%0d err=%b",
                             rd_valid, rd_data, rd_err, e.data, e.err);
                end
            end
        end
    end

    task automatic step(input bit push, input int d, input bit rd, input int off,
                        input bit sl, input int amt, input bit clr);
        int   sz;
        int   eff;
        exp_t e;
        wr_valid  = push;
        wr_data   = DW'(d);
        rd_en     = rd;
        rd_offset = PTR_W'(off);
        slide_en  = sl;
        slide_amt = (PTR_W + 1)'(amt);
        clear     = clr;
        @(posedge clk);
        sz = model.size();
        if (clr) begin
            model.delete();
        end else begin
            if (rd) begin
                if (off < sz) begin
                    e.data = model[off];
                    e.err  = 1'b0;
                end else begin
                    e.data = '0;
                    e.err  = 1'b1;
                end
                sb.push_back(e);
            end
            eff = sl ? ((amt < sz) ? amt : sz) : 0;
            repeat (eff) void'(model.pop_front());
            if (push && sz < DEPTH) model.push_back(DW'(d));
        end
        #1;
        wr_valid = 1'b0;
        rd_en    = 1'b0;
        slide_en = 1'b0;
        clear    = 1'b0;
    endtask

    task automatic test_reset();
        checks++;
        if (count !== 4'd0 || empty !== 1'b1 || full !== 1'b0 || wr_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_status: count=%0d empty=%b full=%b wr_ready=%b, expected 0 1 0 1",
                     count, empty, full, wr_ready);
        end
        checks++;
        if (rd_data !== 16'd0 || rd_valid !== 1'b0 || rd_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_read: rd_data=%0d rd_valid=%b rd_err=%b, expected 0 0 0",
                     rd_data, rd_valid, rd_err);
        end
    endtask

    task automatic test_basic();
        for (int i = 1; i <= 3; i++) step(1, i, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 1, i, 0, 0, 0);
            checks++;
            if (rd_data !== DW'(i + 1)) begin
                errors++;
                $display("FAIL basic_read%0d: rd_data=%0d expected=%0d", i, rd_data, i + 1);
            end
        end
        checks++;
        if (count !== 4'd3) begin
            errors++;
            $display("FAIL basic_count: count=%0d expected=3", count);
        end
        step(0, 0, 1, 3, 0, 0, 0);
        checks++;
        if (rd_err !== 1'b1 || rd_data !== 16'd0) begin
            errors++;
            $display("FAIL basic_oob: rd_err=%b rd_data=%0d expected err=1 data=0", rd_err, rd_data);
        end
    endtask

    task automatic test_full();
        step(0, 0, 0, 0, 0, 0, 1);
        for (int i = 0; i < DEPTH; i++) step(1, 10 + i, 0, 0, 0, 0, 0);
        checks++;
        if (full !== 1'b1 || wr_ready !== 1'b0 || count !== 4'd12) begin
            errors++;
            $display("FAIL full_flags: full=%b wr_ready=%b count=%0d expected 1 0 12", full, wr_ready, count);
        end
        step(1, 99, 0, 0, 1, 1, 0);
        checks++;
        if (count !== 4'd11 || full !== 1'b0) begin
            errors++;
            $display("FAIL full_reject: count=%0d full=%b expected 11 0", count, full);
        end
        step(1, 99, 0, 0, 0, 0, 0);
        checks++;
        if (count !== 4'd12) begin
            errors++;
            $display("FAIL full_accept: count=%0d expected=12", count);
        end
        step(0, 0, 1, 11, 0, 0, 0);
        step(0, 0, 1, 0, 0, 0, 0);
    endtask

    task automatic test_wrap();
        step(0, 0, 0, 0, 0, 0, 1);
        for (int i = 0; i < DEPTH; i++) step(1, 10 + i, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1, 5, 0);
        for (int i = 0; i < 5; i++) step(1, 100 + i, 0, 0, 0, 0, 0);
        for (int i = 0; i < DEPTH; i++) begin
            step(0, 0, 1, i, 0, 0, 0);
            checks++;
            if (rd_data !== DW'((i < 7) ? (15 + i) : (93 + i))) begin
                errors++;
                $display("FAIL wrap_read%0d: rd_data=%0d expected=%0d", i, rd_data,
                         (i < 7) ? (15 + i) : (93 + i));
            end
        end
    endtask

    task automatic test_same_cycle();
        step(0, 0, 0, 0, 0, 0, 1);
        for (int i = 1; i <= 4; i++) step(1, i, 0, 0, 0, 0, 0);
        step(1, 5, 1, 0, 1, 2, 0);
        checks++;
        if (rd_data !== 16'd1 || count !== 4'd3) begin
            errors++;
            $display("FAIL same_cycle: rd_data=%0d count=%0d expected 1 3", rd_data, count);
        end
        step(0, 0, 1, 0, 0, 0, 0);
        checks++;
        if (rd_data !== 16'd3) begin
            errors++;
            $display("FAIL same_cycle_next: rd_data=%0d expected=3", rd_data);
        end
    endtask

    task automatic test_slide_clear();
        step(0, 0, 0, 0, 0, 0, 1);
        for (int i = 7; i <= 9; i++) step(1, i, 0, 0, 0, 0, 0);
        step(0, 0, 1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1, 12, 0);
        checks++;
        if (count !== 4'd0 || empty !== 1'b1) begin
            errors++;
            $display("FAIL slide_all: count=%0d empty=%b expected 0 1", count, empty);
        end
        step(1, 55, 1, 0, 0, 0, 1);
        checks++;
        if (count !== 4'd0 || rd_valid !== 1'b0 || rd_err !== 1'b0 || rd_data !== 16'd7) begin
            errors++;
            $display("FAIL clear_prio: count=%0d rd_valid=%b rd_err=%b rd_data=%0d expected 0 0 0 7",
                     count, rd_valid, rd_err, rd_data);
        end
        step(0, 0, 0, 0, 0, 0, 0);
        checks++;
        if (count !== 4'd0 || empty !== 1'b1) begin
            errors++;
            $display("FAIL clear_hold: count=%0d empty=%b expected 0 1", count, empty);
        end
    endtask

    task automatic test_back_to_back();
        step(0, 0, 0, 0, 0, 0, 1);
        for (int n = 0; n < 300; n++) begin
            step(($urandom % 4) != 0, int'($urandom % 65536), $urandom % 2,
                 int'($urandom_range(0, 12)), ($urandom % 4) == 0, int'($urandom_range(0, 12)), 0);
            checks++;
            if (count !== CNT_W'(model.size()) || empty !== (model.size() == 0) ||
                full !== (model.size() == DEPTH)) begin
                errors++;
                $display("FAIL stream_count@%0d: count=%0d empty=%b full=%b expected count=%0d",
                         n, count, empty, full, model.size());
            end
        end
    endtask

    task automatic test_async_reset();
        step(0, 0, 0, 0, 0, 0, 1);
        for (int i = 5; i <= 7; i++) step(1, i, 0, 0, 0, 0, 0);
        step(1, 8, 1, 1, 0, 0, 0);
        #2;
        rst = 1'b1;
        sb.delete();
        model.delete();
        #1;
        checks++;
        if (rd_data !== 16'd0 || rd_valid !== 1'b0 || rd_err !== 1'b0) begin
            errors++;
            $display("FAIL async_rst_read: rd_data=%0d rd_valid=%b rd_err=%b expected 0 0 0",
                     rd_data, rd_valid, rd_err);
        end
        checks++;
        if (count !== 4'd0 || empty !== 1'b1 || full !== 1'b0 || wr_ready !== 1'b1) begin
            errors++;
            $display("FAIL async_rst_status: count=%0d empty=%b full=%b wr_ready=%b expected 0 1 0 1",
                     count, empty, full, wr_ready);
        end
        #3;
        rst = 1'b0;
        step(1, 77, 0, 0, 0, 0, 0);
        step(0, 0, 1, 0, 0, 0, 0);
        checks++;
        if (rd_data !== 16'd77 || count !== 4'd1) begin
            errors++;
            $display("FAIL async_rst_after: rd_data=%0d count=%0d expected 77 1", rd_data, count);
        end
        step(0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        rst       = 1'b1;
        clear     = 1'b0;
        wr_valid  = 1'b0;
        wr_data   = '0;
        rd_en     = 1'b0;
        rd_offset = '0;
        slide_en  = 1'b0;
        slide_amt = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        test_reset();
        test_basic();
        test_full();
        test_wrap();
        test_same_cycle();
        test_slide_clear();
        test_back_to_back();
        test_async_reset();
        step(0, 0, 0, 0, 0, 0, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        errors++;
        $display("FAIL timeout: simulation did not complete within the time limit");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire

// File: doc/ifmap_window_spad.md
# ifmap_window_spad

Parametrised input-feature-map scratchpad for the PE datapath, replacing the flat addressed register array with a circular sliding-window buffer. The ifmap FIFO pushes activations in at the tail. The MAC sequencer reads any element of the live window by offset from the head, then retires the oldest entries by a programmable stride. This supports row-stationary convolution reuse without software address bookkeeping.

## Interface
- DATA_WIDTH, 16, activation width
- DEPTH, 12, entries; need not be a power of two; minimum 2
- PTR_W, $clog2(DEPTH), pointer/offset width (derived)
- CNT_W, $clog2(DEPTH+1), occupancy width (derived)

Ports:
- clk  in  1  single clock; all state changes on rising edge
- rst  in  1  asynchronous, active-high reset
- clear  in  1  synchronous flush; pointers and count go to 0
- wr_valid  in  1  push request
- wr_ready  out  1  high when count < DEPTH
- wr_data  in  DATA_WIDTH  push data
- rd_en  in  1  read request
- rd_offset  in  PTR_W  offset from head (0 = oldest)
- rd_data  out  DATA_WIDTH  registered read data
- rd_valid  out  1  rd_data updated this cycle (1-cycle pulse)
- rd_err  out  1  pulse: last read had offset >= count
- slide_en  in  1  retire entries from head
- slide_amt  in  PTR_W+1  entries to retire; 0..DEPTH
- count  out  CNT_W  current occupancy
- full  out  1  count == DEPTH
- empty  out  1  count == 0

## Operation
- State: storage array[DEPTH], head, tail (PTR_W), count (CNT_W).
- Push accepted when wr_valid && wr_ready: array[tail] <= wr_data; tail advances by 1 modulo DEPTH.
- wr_ready depends only on registered count. A slide in the same cycle does not make a full buffer accept.
- Read with rd_en: if rd_offset < count, then rd_data <= array[(head+rd_offset) mod DEPTH], rd_valid=1, rd_err=0.
- Out-of-window read: rd_data <= 0, rd_valid=1, rd_err=1.
- Without rd_en, rd_data holds its value and rd_valid/rd_err are 0.
- Slide: eff = min(slide_amt, count); head advances by eff modulo DEPTH.
- slide_amt = 0 is a legal no-op.
- Occupancy update: count_next = count + push_accepted − eff. The result always lies in 0..DEPTH.
- Same-cycle precedence: read and slide both use pre-update head and count. A read therefore sees the window before the slide.
- A word pushed in cycle N is readable from cycle N+1.
- clear has priority over push, read and slide: head, tail, count <= 0; rd_valid/rd_err <= 0; rd_data holds.
- Wrap arithmetic: if (ptr + n) >= DEPTH then the result is ptr + n − DEPTH, else ptr + n. Compute in PTR_W+1 bits; no modulo operator.
- Storage contents are not reset. Stale data is unobservable because reads are gated by count.

## Timing
- rd_data/rd_valid/rd_err: 1-cycle latency from rd_en.
- count/full/empty/wr_ready are registered and reflect all updates one cycle after the event.
- Throughput: one push, one read and one slide per cycle, concurrently.
- Reset values: rd_data=0, rd_valid=0, rd_err=0, count=0, full=0, empty=1, wr_ready=1. head=tail=0.
- rst asserted mid-operation: all outputs go to their reset values immediately, without waiting for a clock. Accepted-but-unread data is discarded.
- Deassertion is synchronised upstream; the block does not resynchronise it.

## Structure
- Shared package spad_pkg holds default widths (ACT_WIDTH=16, IFMAP_DEPTH=12) and the wrap-add helper function ptr_wrap_add(ptr, n, depth). These are shared with the filter and psum scratchpads.
- One sub-module, spad_ring_ptr: a PTR_W pointer register with async reset, synchronous clear, and an advance-by-n input. It is instantiated twice (head, tail).
- Top level holds the storage array, count register, read register and the precedence logic.

## Test plan
- Reset then push 1,2,3; read offsets 0,1,2 -> rd_data 1,2,3, one cycle after each rd_en. count=3. Read offset 3 -> rd_data=0, rd_err=1.
- Fill to DEPTH=12 with 10..21 -> full=1, wr_ready=0. Push 99 same cycle as slide_amt=1 -> 99 rejected, count=11. Next push 99 accepted.
- Wrap: fill 12 entries, slide 5, push 5 more (100..104). Read offsets 0..11 -> 15..21, 100..104 in order, across the pointer wrap.
- Same cycle: read offset 0 + slide_amt=2 + push on count=4 (values 1..4) -> rd_data=1. Next cycle count=3; read offset 0 -> 3.
- slide_amt=12 with count=3 -> count=0, empty=1. Then clear asserted together with push -> push ignored, count stays 0.
- Assert rst asynchronously between edges during streaming -> all outputs at reset values before the next edge. Push after release lands at offset 0.
